// File: rtl/sat_pkg.sv
// Shared definitions for the WalkSAT decision stages.
// Holds the flip-mode encodings reported to the flip logic, the FSM state
// encoding of break_min_selector, and the 16-bit Galois LFSR tap constant,
// default seed and step function.
package sat_pkg;

  typedef enum logic [1:0] {
    FREEBIE = 2'b00,
    GREEDY  = 2'b01,
    RANDOM  = 2'b10
  } flip_mode_e;

  typedef enum logic [1:0] {
    COLLECT = 2'b00,
    DECIDE  = 2'b01,
    PICK    = 2'b10,
    OUTPUT  = 2'b11
  } sel_state_e;

  // x^16 + x^14 + x^13 + x^11 + 1 in right-shifting Galois form
  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

  function automatic logic [15:0] lfsr_next(input logic [15:0] q);
    return q[0] ? ((q >> 1) ^ LFSR_TAPS) : (q >> 1);
  endfunction

endpackage

// File: rtl/sat_lfsr16.sv
// 16-bit Galois LFSR, one step per clock, reloads SEED on reset.
// Ports:
//   clk    in   clock
//   reset  in   synchronous active-high reset (loads SEED)
//   state  out  current 16-bit LFSR value
module sat_lfsr16
  import sat_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] state
);

  // An all-zero seed would lock the register at zero forever.
  if (SEED == 16'h0000) begin : g_seed_check
    $error("sat_lfsr16: SEED must be nonzero");
  end

  always_ff @(posedge clk) begin
    if (reset) state <= SEED;
    else       state <= lfsr_next(state);
  end

endmodule

// File: rtl/break_min_selector.sv
// WalkSAT flip-variable decision stage. Collects the break values of the
// candidates of one unsatisfied clause and picks the variable to flip:
// freebie (break==0), else noisy random, else greedy minimum.
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   cand_valid_i / cand_ready_o    candidate beat handshake
//   cand_var_i, cand_break_i       candidate variable and its break value
//   cand_last_i                    last candidate of the clause
//   flip_valid_o / flip_ready_i    decision handshake
//   flip_var_o, flip_break_o       chosen variable and its break value
//   flip_mode_o                    00 freebie, 01 greedy, 10 random
//   overflow_o                     sticky: clause had more than MAX_LITS beats
//
// state   | meaning
// COLLECT | accepting candidate beats, tracking min and first zero
// DECIDE  | one cycle: choose freebie, greedy or random walk
// PICK    | reduce random index modulo count, one subtraction per cycle
// OUTPUT  | decision presented, held until flip_ready_i
module break_min_selector
  import sat_pkg::*;
#(
  parameter int          NUM_CLAUSES  = 20,
  parameter int          NUM_VARS     = 16,
  parameter int          MAX_LITS     = 3,
  parameter logic [7:0]  NOISE_THRESH = 8'd64,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1,
  localparam int BV_BITS  = $clog2(NUM_CLAUSES),
  localparam int VAR_BITS = $clog2(NUM_VARS),
  localparam int LIT_BITS = $clog2(MAX_LITS + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cand_valid_i,
  output logic                cand_ready_o,
  input  logic [VAR_BITS-1:0] cand_var_i,
  input  logic [BV_BITS-1:0]  cand_break_i,
  input  logic                cand_last_i,
  output logic                flip_valid_o,
  input  logic                flip_ready_i,
  output logic [VAR_BITS-1:0] flip_var_o,
  output logic [BV_BITS-1:0]  flip_break_o,
  output logic [1:0]          flip_mode_o,
  output logic                overflow_o
);

  localparam logic [LIT_BITS-1:0] MAX_CNT = LIT_BITS'(MAX_LITS);

  sel_state_e          state, state_nxt;
  logic [VAR_BITS-1:0] cand_var_q [MAX_LITS];
  logic [BV_BITS-1:0]  cand_bv_q  [MAX_LITS];
  logic [LIT_BITS-1:0] count;
  logic [VAR_BITS-1:0] min_var, zero_var;
  logic [BV_BITS-1:0]  min_bv;
  logic                zero_seen;
  logic [LIT_BITS-1:0] r;
  logic [15:0]         lfsr;
  logic                accept, noisy;
  logic                unused_lfsr_bits;

  sat_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .state (lfsr)
  );

  assign unused_lfsr_bits = ^lfsr[7:LIT_BITS];
  assign accept           = cand_valid_i & cand_ready_o;
  assign noisy            = lfsr[15:8] < NOISE_THRESH;
  assign cand_ready_o     = (state == COLLECT);
  assign flip_valid_o     = (state == OUTPUT);

  always_ff @(posedge clk) begin
    if (reset) state <= COLLECT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT: if (accept && cand_last_i) state_nxt = DECIDE;
      DECIDE:  state_nxt = (min_bv != '0 && noisy) ? PICK : OUTPUT;
      PICK:    if (r < count) state_nxt = OUTPUT;
      OUTPUT:  if (flip_ready_i) state_nxt = COLLECT;
      default: state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count        <= '0;
      min_var      <= '0;
      min_bv       <= '0;
      zero_var     <= '0;
      zero_seen    <= 1'b0;
      r            <= '0;
      flip_var_o   <= '0;
      flip_break_o <= '0;
      flip_mode_o  <= FREEBIE;
      overflow_o   <= 1'b0;
      for (int i = 0; i < MAX_LITS; i++) begin
        cand_var_q[i] <= '0;
        cand_bv_q[i]  <= '0;
      end
    end else begin
      case (state)
        COLLECT: begin
          if (accept) begin
            if (count < MAX_CNT) begin
              cand_var_q[count] <= cand_var_i;
              cand_bv_q[count]  <= cand_break_i;
              count             <= count + 1'b1;
              // strict '<' keeps the earliest candidate on ties
              if (count == '0 || cand_break_i < min_bv) begin
                min_var <= cand_var_i;
                min_bv  <= cand_break_i;
              end
              if (!zero_seen && cand_break_i == '0) begin
                zero_seen <= 1'b1;
                zero_var  <= cand_var_i;
              end
            end else begin
              overflow_o <= 1'b1;
            end
          end
        end
        DECIDE: begin
          if (min_bv == '0) begin
            flip_var_o   <= zero_var;
            flip_break_o <= '0;
            flip_mode_o  <= FREEBIE;
          end else if (noisy) begin
            r           <= lfsr[LIT_BITS-1:0];
            flip_mode_o <= RANDOM;
          end else begin
            flip_var_o   <= min_var;
            flip_break_o <= min_bv;
            flip_mode_o  <= GREEDY;
          end
        end
        PICK: begin
          if (r >= count) begin
            r <= r - count;
          end else begin
            flip_var_o   <= cand_var_q[r];
            flip_break_o <= cand_bv_q[r];
          end
        end
        OUTPUT: begin
          if (flip_ready_i) begin
            count     <= '0;
            min_var   <= '0;
            min_bv    <= '0;
            zero_var  <= '0;
            zero_seen <= 1'b0;
            r         <= '0;
            for (int i = 0; i < MAX_LITS; i++) begin
              cand_var_q[i] <= '0;
              cand_bv_q[i]  <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_break_min_selector.sv
// Directed bench for break_min_selector. Three instances share the candidate
// stream: index 0 default noise (64), index 1 noise 0 (never random),
// index 2 noise 8'hFF (random unless LFSR top byte is FF).
module tb_break_min_selector;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic             cand_valid;
  logic [3:0]       cand_var;
  logic [4:0]       cand_break;
  logic             cand_last;
  logic [2:0]       crdy, fv, frdy, ovf;
  logic [2:0][3:0]  fvar;
  logic [2:0][4:0]  fbv;
  logic [2:0][1:0]  fmode;

  int n_cmp = 0;
  int n_err = 0;
  int cv[5];
  int cb[5];
  logic [15:0] m_lfsr;

  break_min_selector #(.NOISE_THRESH(8'd64)) u_dflt (
    .clk(clk), .reset(reset),
    .cand_valid_i(cand_valid), .cand_ready_o(crdy[0]),
    .cand_var_i(cand_var), .cand_break_i(cand_break), .cand_last_i(cand_last),
    .flip_valid_o(fv[0]), .flip_ready_i(frdy[0]),
    .flip_var_o(fvar[0]), .flip_break_o(fbv[0]), .flip_mode_o(fmode[0]),
    .overflow_o(ovf[0]));

  break_min_selector #(.NOISE_THRESH(8'd0)) u_greedy (
    .clk(clk), .reset(reset),
    .cand_valid_i(cand_valid), .cand_ready_o(crdy[1]),
    .cand_var_i(cand_var), .cand_break_i(cand_break), .cand_last_i(cand_last),
    .flip_valid_o(fv[1]), .flip_ready_i(frdy[1]),
    .flip_var_o(fvar[1]), .flip_break_o(fbv[1]), .flip_mode_o(fmode[1]),
    .overflow_o(ovf[1]));

  break_min_selector #(.NOISE_THRESH(8'hFF)) u_rand (
    .clk(clk), .reset(reset),
    .cand_valid_i(cand_valid), .cand_ready_o(crdy[2]),
    .cand_var_i(cand_var), .cand_break_i(cand_break), .cand_last_i(cand_last),
    .flip_valid_o(fv[2]), .flip_ready_i(frdy[2]),
    .flip_var_o(fvar[2]), .flip_break_o(fbv[2]), .flip_mode_o(fmode[2]),
    .overflow_o(ovf[2]));

  // Reference LFSR: shift right, feedback bit into positions 15,13,12,10.
  function automatic logic [15:0] ref_lfsr_step(input logic [15:0] q);
    logic [15:0] n;
    logic        fb;
    fb = q[0];
    n  = {1'b0, q[15:1]};
    n[15] = n[15] ^ fb;
    n[13] = n[13] ^ fb;
    n[12] = n[12] ^ fb;
    n[10] = n[10] ^ fb;
    return n;
  endfunction

  always @(posedge clk) m_lfsr <= reset ? 16'hACE1 : ref_lfsr_step(m_lfsr);

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_all_ready();
    int n;
    n = 0;
    while (crdy != 3'b111 && n < 30) begin
      step();
      n++;
    end
    check("idle_ready", int'(crdy), 7);
  endtask

  task automatic send_clause(input int n, input bit with_last);
    for (int i = 0; i < n; i++) begin
      cand_valid = 1'b1;
      cand_var   = 4'(cv[i]);
      cand_break = 5'(cb[i]);
      cand_last  = with_last && (i == n - 1);
      step();
    end
    cand_valid = 1'b0;
    cand_last  = 1'b0;
  endtask

  // Called in the cycle after the last beat (lat=1); counts cycles to flip_valid.
  task automatic wait_flip(input int idx, output int lat);
    lat = 1;
    while (!fv[idx] && lat < 20) begin
      step();
      lat++;
    end
  endtask

  task automatic check_flip(input string tag, input int idx, input int ev,
                            input int eb, input int em, input int el);
    int lat;
    wait_flip(idx, lat);
    check({tag, "_lat"},  lat, el);
    check({tag, "_var"},  int'(fvar[idx]), ev);
    check({tag, "_bv"},   int'(fbv[idx]), eb);
    check({tag, "_mode"}, int'(fmode[idx]), em);
  endtask

  // Expected outcome for the noise-FF instance; must be called in DECIDE.
  task automatic rand_expect(input int cnt, input int gv, input int gb,
                             output int ev, output int eb, output int em, output int el);
    int rr, k;
    if (m_lfsr[15:8] < 8'hFF) begin
      rr = int'(m_lfsr[1:0]);
      k  = 0;
      while (rr >= cnt) begin
        rr -= cnt;
        k++;
      end
      ev = cv[rr]; eb = cb[rr]; em = 2; el = 3 + k;
    end else begin
      ev = gv; eb = gb; em = 1; el = 2;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ev, eb, em, el;
    int hits[16];
    reset = 1'b1; cand_valid = 1'b0; cand_var = '0; cand_break = '0;
    cand_last = 1'b0; frdy = 3'b111;
    foreach (hits[i]) hits[i] = 0;
    step(); step();
    check("rst_cand_ready", int'(crdy[0]), 1);
    check("rst_flip_valid", int'(fv[0]), 0);
    check("rst_flip_var",   int'(fvar[0]), 0);
    check("rst_flip_bv",    int'(fbv[0]), 0);
    check("rst_flip_mode",  int'(fmode[0]), 0);
    check("rst_overflow",   int'(ovf[0]), 0);
    reset = 1'b0;
    step();

    // partial clause discarded by reset
    cv = '{1, 2, 0, 0, 0}; cb = '{0, 0, 0, 0, 0};
    send_clause(2, 1'b0);
    reset = 1'b1; step(); step(); reset = 1'b0;
    check("midrst_cand_ready", int'(crdy), 7);
    check("midrst_flip_valid", int'(fv), 0);
    check("midrst_overflow",   int'(ovf), 0);

    // freebie: first zero (var 7) wins over later zero and earlier nonzero
    cv = '{3, 7, 9, 0, 0}; cb = '{2, 0, 0, 0, 0};
    send_clause(3, 1'b1);
    check_flip("freebie", 0, 7, 0, 0, 2);
    check("freebie_overflow", int'(ovf[0]), 0);
    wait_all_ready();

    // greedy with tie: earliest minimum wins
    cv = '{5, 2, 8, 0, 0}; cb = '{3, 1, 1, 0, 0};
    send_clause(3, 1'b1);
    check_flip("greedy_tie", 1, 2, 1, 1, 2);
    wait_all_ready();

    // single-beat clause, greedy instance
    cv[0] = 7; cb[0] = 3;
    send_clause(1, 1'b1);
    check_flip("single_greedy", 1, 7, 3, 1, 2);
    wait_all_ready();

    // single-beat clause, random instance: r reduced down to 0
    cv[0] = 13; cb[0] = 6;
    send_clause(1, 1'b1);
    rand_expect(1, 13, 6, ev, eb, em, el);
    check_flip("single_rand", 2, ev, eb, em, el);
    wait_all_ready();

    // random walk over many clauses
    cv = '{1, 4, 6, 0, 0}; cb = '{4, 2, 3, 0, 0};
    for (int c = 0; c < 1000; c++) begin
      send_clause(3, 1'b1);
      rand_expect(3, 4, 2, ev, eb, em, el);
      check_flip("random", 2, ev, eb, em, el);
      hits[fvar[2]]++;
      wait_all_ready();
    end
    check("random_hit_var1", int'(hits[1] > 0), 1);
    check("random_hit_var4", int'(hits[4] > 0), 1);
    check("random_hit_var6", int'(hits[6] > 0), 1);

    // backpressure on the greedy instance
    frdy[1] = 1'b0;
    cv = '{10, 11, 12, 0, 0}; cb = '{4, 2, 3, 0, 0};
    send_clause(3, 1'b1);
    check_flip("bp", 1, 11, 2, 1, 2);
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_valid", int'(fv[1]), 1);
      check("bp_hold_var",   int'(fvar[1]), 11);
      check("bp_hold_bv",    int'(fbv[1]), 2);
      check("bp_hold_mode",  int'(fmode[1]), 1);
      check("bp_cand_ready", int'(crdy[1]), 0);
      step();
    end
    frdy[1] = 1'b1;
    step();
    check("bp_release_ready", int'(crdy[1]), 1);
    check("bp_release_valid", int'(fv[1]), 0);
    wait_all_ready();

    // overflow: 5 beats, only the first 3 count
    cv = '{1, 2, 3, 4, 5}; cb = '{5, 4, 3, 0, 1};
    send_clause(5, 1'b1);
    check("ovf_set", int'(ovf[1]), 1);
    check_flip("ovf", 1, 3, 3, 1, 2);
    wait_all_ready();
    check("ovf_sticky_idle", int'(ovf[1]), 1);
    cv[0] = 6; cb[0] = 2;
    send_clause(1, 1'b1);
    check_flip("after_ovf", 1, 6, 2, 1, 2);
    check("ovf_sticky_next", int'(ovf[1]), 1);
    wait_all_ready();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
